// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: byte-serial port onto the 8-bit external RAM/IO bus, shared by the
// instruction fetcher (multi-word bursts) and the LSU (byte/half/word, unaligned allowed).
// One access is in flight at a time; simultaneous requests alternate between the two clients.
module mem_port_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                BURST_WORDS = 4,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(32'h0003_0000)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic [7:0]                     mem_din,
  output logic [7:0]                     mem_dout,
  output logic [ADDR_W-1:0]              mem_a,
  output logic                           mem_wr,
  input  logic                           io_full_in,
  input  logic                           if_req,
  input  logic [ADDR_W-1:0]              if_addr,
  input  logic                           if_flush,
  output logic                           if_word_vld,
  output logic [31:0]                    if_word,
  output logic [$clog2(BURST_WORDS):0]   if_word_idx,
  output logic                           if_done,
  input  logic                           ls_req,
  input  logic                           ls_we,
  input  logic [1:0]                     ls_size,
  input  logic [ADDR_W-1:0]              ls_addr,
  input  logic [31:0]                    ls_wdata,
  output logic [31:0]                    ls_rdata,
  output logic                           ls_done,
  output logic                           busy_out
);

  localparam int IDX_W = $clog2(BURST_WORDS) + 1;
  localparam int CNT_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(4 * BURST_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    LS_RD,
    LS_WR,
    IO_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [CNT_W-1:0]  last_cnt;
  logic [31:0]       rbuf;
  logic [31:0]       wsh;
  logic [ADDR_W-1:0] io_addr;
  logic              last_ls;

  logic [31:0]       rd_merge;
  logic              ls_is_io;
  logic [CNT_W-1:0]  ls_last;
  logic              grant_ls;
  logic              grant_if;

  // Read buffer with the byte arriving this cycle slotted into its little-endian lane
  always_comb begin
    rd_merge = rbuf;
    case (byte_cnt[1:0])
      2'd0:    rd_merge[7:0]   = mem_din;
      2'd1:    rd_merge[15:8]  = mem_din;
      2'd2:    rd_merge[23:16] = mem_din;
      default: rd_merge[31:24] = mem_din;
    endcase
  end

  // Arbitration and LSU length decode; IO space is always a single-byte access
  always_comb begin
    ls_is_io = (ls_addr >= IO_BASE);
    ls_last  = '0;
    if (!ls_is_io) begin
      case (ls_size)
        2'd0:    ls_last = '0;
        2'd1:    ls_last = CNT_W'(1);
        default: ls_last = CNT_W'(3);
      endcase
    end
    grant_ls = ls_req && (!if_req || !last_ls);
    grant_if = if_req && !grant_ls;
  end

  // Access sequencer: grants in IDLE, then walks the bytes of the granted access one per cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      last_cnt    <= '0;
      rbuf        <= '0;
      wsh         <= '0;
      io_addr     <= '0;
      last_ls     <= 1'b0;
      mem_a       <= '0;
      mem_dout    <= '0;
      mem_wr      <= 1'b0;
      if_word_vld <= 1'b0;
      if_word     <= '0;
      if_word_idx <= '0;
      if_done     <= 1'b0;
      ls_rdata    <= '0;
      ls_done     <= 1'b0;
    end else if (rdy_in) begin
      ls_done     <= 1'b0;
      if_word_vld <= 1'b0;
      if_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            last_ls  <= 1'b1;
            byte_cnt <= '0;
            last_cnt <= ls_last;
            rbuf     <= '0;
            if (!ls_we) begin
              state <= LS_RD;
              mem_a <= ls_addr;
            end else if (ls_is_io && io_full_in) begin
              state   <= IO_WAIT;
              io_addr <= ls_addr;
              wsh     <= ls_wdata;
            end else begin
              state    <= LS_WR;
              mem_a    <= ls_addr;
              mem_wr   <= 1'b1;
              mem_dout <= ls_wdata[7:0];
              wsh      <= {8'd0, ls_wdata[31:8]};
            end
          end else if (grant_if) begin
            last_ls  <= 1'b0;
            state    <= IF_RD;
            mem_a    <= if_addr;
            byte_cnt <= '0;
            last_cnt <= FETCH_LAST;
          end
        end

        IO_WAIT: begin
          if (!io_full_in) begin
            state    <= LS_WR;
            mem_a    <= io_addr;
            mem_wr   <= 1'b1;
            mem_dout <= wsh[7:0];
          end
        end

        LS_WR: begin
          if (byte_cnt == last_cnt) begin
            state    <= IDLE;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            ls_done  <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            mem_a    <= mem_a + ADDR_W'(1);
            mem_dout <= wsh[7:0];
            wsh      <= {8'd0, wsh[31:8]};
          end
        end

        LS_RD: begin
          rbuf <= rd_merge;
          if (byte_cnt == last_cnt) begin
            state    <= IDLE;
            mem_a    <= '0;
            ls_rdata <= rd_merge;
            ls_done  <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            mem_a    <= mem_a + ADDR_W'(1);
          end
        end

        IF_RD: begin
          if (if_flush) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            rbuf <= rd_merge;
            if (byte_cnt[1:0] == 2'd3) begin
              if_word_vld <= 1'b1;
              if_word     <= rd_merge;
              if_word_idx <= byte_cnt[CNT_W-1:2];
            end
            if (byte_cnt == last_cnt) begin
              state   <= IDLE;
              mem_a   <= '0;
              if_done <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
              mem_a    <= mem_a + ADDR_W'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          mem_a  <= '0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared byte-serial RAM port.
// Expected writes, load results and fetch words are queued when a request is driven
// and retired by a monitor as the DUT produces them.
module tb_mem_port_arbiter;

  localparam int          BURST_WORDS = 4;
  localparam int          IDX_W       = $clog2(BURST_WORDS) + 1;
  localparam logic [31:0] IO_BASE     = 32'h0003_0000;

  logic             clk_in;
  logic             rst_in;
  logic             rdy_in;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             io_full_in;
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_flush;
  logic             if_word_vld;
  logic [31:0]      if_word;
  logic [IDX_W-1:0] if_word_idx;
  logic             if_done;
  logic             ls_req;
  logic             ls_we;
  logic [1:0]       ls_size;
  logic [31:0]      ls_addr;
  logic [31:0]      ls_wdata;
  logic [31:0]      ls_rdata;
  logic             ls_done;
  logic             busy_out;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
  } ls_t;

  typedef struct {
    logic [31:0]      word;
    logic [IDX_W-1:0] idx;
    logic             done;
  } if_t;

  wr_t exp_wr[$];
  ls_t exp_ls[$];
  if_t exp_if[$];
  wr_t wr_e;
  ls_t ls_e;
  if_t if_e;

  logic [7:0] ram [logic [31:0]];

  int check_count = 0;
  int pass_count  = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .BURST_WORDS (BURST_WORDS),
    .IO_BASE     (IO_BASE)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .mem_a       (mem_a),
    .mem_wr      (mem_wr),
    .io_full_in  (io_full_in),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_flush    (if_flush),
    .if_word_vld (if_word_vld),
    .if_word     (if_word),
    .if_word_idx (if_word_idx),
    .if_done     (if_done),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_size     (ls_size),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_rdata    (ls_rdata),
    .ls_done     (ls_done),
    .busy_out    (busy_out)
  );

  // Free-running clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Absolute time limit in case some wait never resolves
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [7:0] ram_read(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] addr, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ram_read(addr + 32'(k));
    return w;
  endfunction

  function automatic int lsu_len(input logic [31:0] addr, input logic [1:0] size);
    if (addr >= IO_BASE) return 1;
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  // RAM model: the byte for the address of the current cycle is on mem_din by the closing edge
  always @(negedge clk_in) mem_din = ram_read(mem_a);

  // RAM model write port, frozen together with the DUT by rdy_in
  always @(posedge clk_in) begin
    if (rst_in && rdy_in && mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Monitor: retires scoreboard entries as writes, LSU completions and fetch words appear
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (mem_wr) begin
        if (exp_wr.size() == 0) checkOutput("wr_unexpected", 64'(exp_wr.size()), 64'd1);
        else begin
          wr_e = exp_wr.pop_front();
          checkOutput("wr_addr", 64'(mem_a), 64'(wr_e.addr));
          checkOutput("wr_data", 64'(mem_dout), 64'(wr_e.data));
        end
      end
      if (ls_done) begin
        if (exp_ls.size() == 0) checkOutput("ls_done_unexpected", 64'(exp_ls.size()), 64'd1);
        else begin
          ls_e = exp_ls.pop_front();
          if (ls_e.is_load) checkOutput("ls_rdata", 64'(ls_rdata), 64'(ls_e.data));
        end
      end
      if (if_word_vld) begin
        if (exp_if.size() == 0) checkOutput("if_vld_unexpected", 64'(exp_if.size()), 64'd1);
        else begin
          if_e = exp_if.pop_front();
          checkOutput("if_word", 64'(if_word), 64'(if_e.word));
          checkOutput("if_idx", 64'(if_word_idx), 64'(if_e.idx));
          checkOutput("if_done", 64'(if_done), 64'(if_e.done));
        end
      end else if (if_done) begin
        checkOutput("if_done_without_vld", 64'(if_word_vld), 64'd1);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expect_done);
    int  n;
    wr_t w;
    ls_t l;
    n        = lsu_len(addr, size);
    ls_we    = we;
    ls_size  = size;
    ls_addr  = addr;
    ls_wdata = wdata;
    ls_req   = 1'b1;
    if (expect_done) begin
      if (we) begin
        for (int k = 0; k < n; k++) begin
          w.addr = addr + 32'(k);
          w.data = wdata[8*k +: 8];
          exp_wr.push_back(w);
        end
        l.is_load = 1'b0;
        l.data    = '0;
      end else begin
        l.is_load = 1'b1;
        l.data    = ram_word(addr, n);
      end
      exp_ls.push_back(l);
    end
  endtask

  task automatic pushFetch(input logic [31:0] addr, input int count);
    if_t e;
    for (int w = 0; w < count; w++) begin
      e.word = ram_word(addr + 32'(4 * w), 4);
      e.idx  = IDX_W'(w);
      e.done = (w == BURST_WORDS - 1);
      exp_if.push_back(e);
    end
  endtask

  task automatic runLsu(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
    int n;
    @(negedge clk_in);
    applyStimulus(we, size, addr, wdata, 1'b1);
    @(negedge clk_in);
    checkOutput({tag, "_busy"}, 64'(busy_out), 64'd1);
    n = 0;
    while (!ls_done && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    ls_req = 1'b0;
    checkOutput({tag, "_latency"}, 64'(n), 64'(exp_lat));
    @(negedge clk_in);
    checkOutput({tag, "_after"}, 64'({ls_done, busy_out, mem_wr}), 64'd0);
  endtask

  task automatic runFetch(input string tag, input logic [31:0] addr, input int flush_at);
    int n;
    int w;
    int busy_cnt;
    int want;
    bit stop;
    want = (flush_at < 0) ? BURST_WORDS : flush_at + 1;
    @(negedge clk_in);
    pushFetch(addr, want);
    if_addr = addr;
    if_req  = 1'b1;
    @(negedge clk_in);
    n = 0;
    w = 0;
    busy_cnt = 0;
    stop = 1'b0;
    while (!stop && n < 200) begin
      if (busy_out) busy_cnt++;
      if (if_word_vld) begin
        checkOutput({tag, "_vld_time"}, 64'(n), 64'(4 * (w + 1)));
        if (w == flush_at) begin
          if_flush = 1'b1;
          if_req   = 1'b0;
          stop     = 1'b1;
        end
        w++;
      end
      if (if_done) stop = 1'b1;
      if (!stop) begin
        @(negedge clk_in);
        n++;
      end
    end
    if_req = 1'b0;
    checkOutput({tag, "_words"}, 64'(w), 64'(want));
    if (flush_at < 0) checkOutput({tag, "_read_cycles"}, 64'(busy_cnt), 64'(4 * BURST_WORDS));
    @(negedge clk_in);
    checkOutput({tag, "_idle"}, 64'(busy_out), 64'd0);
    checkOutput({tag, "_no_pulse"}, 64'({if_word_vld, if_done}), 64'd0);
    if_flush = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  // Main sequence
  initial begin
    int n;
    int k;
    int got [4];

    rst_in = 1'b1;
    rdy_in = 1'b1;
    io_full_in = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    if_flush = 1'b0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    ls_size = '0;
    ls_addr = '0;
    ls_wdata = '0;
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;
    #2 rst_in = 1'b0;

    repeat (3) @(negedge clk_in);
    checkOutput("reset_mem_a", 64'(mem_a), 64'd0);
    checkOutput("reset_wr_dout", 64'({mem_wr, mem_dout}), 64'd0);
    checkOutput("reset_pulses", 64'({ls_done, if_word_vld, if_done, busy_out}), 64'd0);
    checkOutput("reset_data", {if_word, ls_rdata}, 64'd0);
    checkOutput("reset_idx", 64'(if_word_idx), 64'd0);
    rst_in = 1'b1;

    runLsu("ld_word", 1'b0, 2'd2, 32'h0000_0100, 32'h0, 4);
    runLsu("st_half", 1'b1, 2'd1, 32'h0000_0203, 32'h0000_BEEF, 2);
    runLsu("ld_half_unaligned", 1'b0, 2'd1, 32'h0000_0101, 32'h0, 2);
    runLsu("st_word_unaligned", 1'b1, 2'd3, 32'h0000_01FE, 32'hCAFE_F00D, 4);
    runLsu("ld_byte", 1'b0, 2'd0, 32'h0000_0102, 32'h0, 1);
    runLsu("io_ld_forced_byte", 1'b0, 2'd2, 32'h0003_0010, 32'h0, 1);

    // IO store held off by a full output buffer for five cycles
    @(negedge clk_in);
    io_full_in = 1'b1;
    applyStimulus(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041, 1'b1);
    @(negedge clk_in);
    checkOutput("io_wait_busy", 64'(busy_out), 64'd1);
    checkOutput("io_wait_port", 64'({mem_wr, mem_a}), 64'd0);
    n = 0;
    while (!ls_done && n < 100) begin
      if (n == 5) io_full_in = 1'b0;
      @(negedge clk_in);
      n++;
    end
    ls_req = 1'b0;
    checkOutput("io_st_latency", 64'(n), 64'd7);

    // Global ready low for three cycles in the middle of a word load
    @(negedge clk_in);
    applyStimulus(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b1);
    @(negedge clk_in);
    n = 0;
    while (!ls_done && n < 100) begin
      if (n == 1) rdy_in = 1'b0;
      if (n == 4) begin
        checkOutput("stall_hold_addr", 64'(mem_a), 64'h101);
        rdy_in = 1'b1;
      end
      @(negedge clk_in);
      n++;
    end
    ls_req = 1'b0;
    checkOutput("stall_latency", 64'(n), 64'd7);

    runFetch("fetch", 32'h0000_0000, -1);

    // Both clients requesting continuously: grants alternate, LSU first after a fetch
    @(negedge clk_in);
    applyStimulus(1'b0, 2'd0, 32'h0000_0100, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'd0, 32'h0000_0100, 32'h0, 1'b1);
    pushFetch(32'h0000_0040, BURST_WORDS);
    pushFetch(32'h0000_0040, BURST_WORDS);
    if_addr = 32'h0000_0040;
    if_req  = 1'b1;
    for (int i = 0; i < 4; i++) got[i] = -1;
    k = 0;
    n = 0;
    while (k < 4 && n < 300) begin
      @(negedge clk_in);
      n++;
      if (ls_done) begin
        got[k] = 1;
        k++;
      end else if (if_done) begin
        got[k] = 0;
        k++;
      end
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("alt_grant%0d", i), 64'(got[i]), 64'((i % 2 == 0) ? 1 : 0));
    repeat (4) @(negedge clk_in);

    runFetch("flush_wrap", 32'hFFFF_FFF8, 2);

    // Reset in the middle of a load: outputs clear at once and no completion follows
    @(negedge clk_in);
    applyStimulus(1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("pre_reset_busy", 64'(busy_out), 64'd1);
    rst_in = 1'b0;
    #1;
    checkOutput("mid_reset_port", 64'({mem_wr, mem_a}), 64'd0);
    checkOutput("mid_reset_busy", 64'({busy_out, ls_done}), 64'd0);
    ls_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (6) @(negedge clk_in);

    checkOutput("pending_writes", 64'(exp_wr.size()), 64'd0);
    checkOutput("pending_lsu", 64'(exp_ls.size()), 64'd0);
    checkOutput("pending_fetch", 64'(exp_if.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
